// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with exact occupancy count, threshold flags,
// sticky overflow/underflow and a synchronous flush that dominates traffic.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  isEmpty,
  output logic                  isFull,
  output logic                  almostEmpty,
  output logic                  almostFull,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] ZERO_C   = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  ovf_evt_s;
  logic                  unf_evt_s;

  assign empty_s = (count_r == ZERO_C);
  assign full_s  = (count_r == DEPTH_C);

  // Accept/reject decisions; a full FIFO still takes a write when a pop frees a slot.
  always_comb begin
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    if (clear) begin
      rd_en_s   = 1'b0;
      wr_en_s   = 1'b0;
    end else begin
      rd_en_s   = re && !empty_s;
      wr_en_s   = we && (!full_s || (re && !empty_s));
      ovf_evt_s = we && !(!full_s || (re && !empty_s));
      unf_evt_s = re && empty_s;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= dataIn;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
      overflow_r  <= overflow_r  | ovf_evt_s;
      underflow_r <= underflow_r | unf_evt_s;
    end
  end

  assign dataOut     = mem_r[rd_ptr_r];
  assign count       = count_r;
  assign isEmpty     = empty_s;
  assign isFull      = full_s;
  assign almostEmpty = (count_r <= AEMPTY_C);
  assign almostFull  = (count_r >= AFULL_C);
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param at default parameters (8 x 16, thresholds 12/2).
module tb_fifo_sync_param;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       we;
  logic [7:0] dataIn;
  logic       re;
  logic [7:0] dataOut;
  logic [4:0] count;
  logic       isEmpty;
  logic       isFull;
  logic       almostEmpty;
  logic       almostFull;
  logic       overflow;
  logic       underflow;

  logic [7:0] sb_q[$];
  logic       m_ovf;
  logic       m_unf;
  int         vec_cnt;
  int         err_cnt;

  fifo_sync_param dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .dataIn(dataIn),
    .re(re), .dataOut(dataOut), .count(count), .isEmpty(isEmpty),
    .isFull(isFull), .almostEmpty(almostEmpty), .almostFull(almostFull),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every status output against the model, plus the head word when non-empty.
  task automatic check_state(input string tag);
    int n;
    n = sb_q.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(isEmpty), 32'(n == 0));
    check({tag, ".full"}, 32'(isFull), 32'(n == 16));
    check({tag, ".aempty"}, 32'(almostEmpty), 32'(n <= 2));
    check({tag, ".afull"}, 32'(almostFull), 32'(n >= 12));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    if (n != 0) check({tag, ".head"}, 32'(dataOut), 32'(sb_q[0]));
  endtask

  // One clock of traffic; called #1 after a rising edge, returns #1 after the next.
  task automatic op(input string tag, input logic w, input logic [7:0] d, input logic r);
    logic rd_ok;
    logic wr_ok;
    we = w; dataIn = d; re = r;
    rd_ok = r && (sb_q.size() != 0);
    wr_ok = w && ((sb_q.size() < 16) || rd_ok);
    if (r && sb_q.size() == 0) m_unf = 1'b1;
    if (w && !wr_ok) m_ovf = 1'b1;
    if (rd_ok) begin
      check({tag, ".pop"}, 32'(dataOut), 32'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (wr_ok) sb_q.push_back(d);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    check_state(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1; we = 1'b1; re = 1'b1; dataIn = 8'hEE;
    @(posedge clk); #1;
    clear = 1'b0; we = 1'b0; re = 1'b0;
    sb_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state("clear");
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    m_ovf = 1'b0; m_unf = 1'b0;
    reset_n = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0; dataIn = 8'h00;
    #2 reset_n = 1'b0;
    #2 check_state("reset");
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 16; i++) op("fill", 1'b1, 8'(i), 1'b0);
    op("ovf", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) op("drain", 1'b0, 8'h00, 1'b1);
    op("unf", 1'b0, 8'h00, 1'b1);

    // Simultaneous push/pop at full
    do_clear();
    for (int i = 0; i < 16; i++) op("refill", 1'b1, 8'(8'h10 + i), 1'b0);
    op("fullwr", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 15; i++) op("drain2", 1'b0, 8'h00, 1'b1);
    check("a5_head", 32'(dataOut), 32'h0000_00A5);
    op("drain2", 1'b0, 8'h00, 1'b1);

    // Simultaneous push/pop at empty
    do_clear();
    op("emptywr", 1'b1, 8'h3C, 1'b1);
    check("3c_out", 32'(dataOut), 32'h0000_003C);

    // Random interleaving across pointer wrap
    do_clear();
    for (int i = 0; i < 10; i++) op("pre", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++)
      op("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    do_clear();

    // Async reset mid-traffic, checked before any further clock edge
    for (int i = 0; i < 5; i++) op("pre_rst", 1'b1, 8'(8'h50 + i), 1'b0);
    op("pre_rst", 1'b0, 8'h00, 1'b1);
    op("pre_rst", 1'b0, 8'h00, 1'b1);
    op("pre_rst", 1'b0, 8'h00, 1'b1);
    op("pre_rst", 1'b0, 8'h00, 1'b1);
    op("pre_rst", 1'b0, 8'h00, 1'b1);
    op("pre_rst", 1'b0, 8'h00, 1'b1);
    op("pre_rst", 1'b1, 8'h77, 1'b0);
    op("pre_rst", 1'b1, 8'h78, 1'b0);
    we = 1'b1; dataIn = 8'h99;
    #1 reset_n = 1'b0;
    #2;
    sb_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state("async_rst");
    we = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    op("post_rst", 1'b1, 8'h42, 1'b0);
    op("post_rst", 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
